// File: rtl/fpu_issue_ctrl_if.sv
// Signal bundle between the FPU issue sequencer and its environment (core request side,
// FPU start/done side, FP register file write-back side).
interface fpu_issue_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_rd;

    logic        fpu_start;
    logic [2:0]  fpu_op;
    logic [31:0] fpu_n1;
    logic [31:0] fpu_n2;
    logic [31:0] fpu_result;
    logic        fpu_done;

    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        stall;
    logic        err_illegal;
    logic        err_timeout;

    // The sequencer masters the FPU handshake and the write-back strobe.
    modport master (
        input  req_valid, req_op, req_rs1, req_rs2, req_rd, fpu_result, fpu_done,
        output req_ready, fpu_start, fpu_op, fpu_n1, fpu_n2,
               wb_valid, wb_rd, wb_data, stall, err_illegal, err_timeout
    );

    modport slave (
        output req_valid, req_op, req_rs1, req_rs2, req_rd, fpu_result, fpu_done,
        input  req_ready, fpu_start, fpu_op, fpu_n1, fpu_n2,
               wb_valid, wb_rd, wb_data, stall, err_illegal, err_timeout
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FPU issue sequencer: one F-extension op at a time, start/done handshake, single-cycle write-back.
// Optional WAIT-state watchdog compiled in with `define FPU_ISSUE_TIMEOUT_EN.
module fpu_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    fpu_issue_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        WB
    } state_t;

    localparam logic [2:0] OP_LAST_LEGAL = 3'b101;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("fpu_issue_ctrl: TIMEOUT_CYCLES must be within 2..1023");
    end

    state_t state;

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam logic [9:0] WAIT_LIMIT = 10'(TIMEOUT_CYCLES - 1);
    logic [9:0] wait_cnt;
`endif

    // Every output is a flop; pulses default low and are raised only for the cycle they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.req_ready   <= 1'b1;
            bus.stall       <= 1'b0;
            bus.fpu_start   <= 1'b0;
            bus.fpu_op      <= '0;
            bus.fpu_n1      <= '0;
            bus.fpu_n2      <= '0;
            bus.wb_valid    <= 1'b0;
            bus.wb_rd       <= '0;
            bus.wb_data     <= '0;
            bus.err_illegal <= 1'b0;
            bus.err_timeout <= 1'b0;
`ifdef FPU_ISSUE_TIMEOUT_EN
            wait_cnt        <= '0;
`endif
        end else begin
            bus.fpu_start   <= 1'b0;
            bus.wb_valid    <= 1'b0;
            bus.err_illegal <= 1'b0;
            bus.err_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.fpu_op <= bus.req_op;
                        bus.fpu_n1 <= bus.req_rs1;
                        bus.fpu_n2 <= bus.req_rs2;
                        bus.wb_rd  <= bus.req_rd;
                        if (bus.req_op > OP_LAST_LEGAL) begin
                            bus.err_illegal <= 1'b1;
                        end else begin
                            state         <= ISSUE;
                            bus.fpu_start <= 1'b1;
                            bus.req_ready <= 1'b0;
                            bus.stall     <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    state <= WAIT;
`ifdef FPU_ISSUE_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end

                // A done pulse in the expiry cycle is checked first, so it still writes back.
                WAIT: begin
                    if (bus.fpu_done) begin
                        bus.wb_data  <= bus.fpu_result;
                        bus.wb_valid <= 1'b1;
                        state        <= WB;
                    end
`ifdef FPU_ISSUE_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LIMIT) begin
                        bus.err_timeout <= 1'b1;
                        bus.req_ready   <= 1'b1;
                        bus.stall       <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 10'd1;
                    end
`endif
                end

                WB: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                    bus.stall     <= 1'b0;
                end

                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                    bus.stall     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: vector table plus hand sequences, with a behavioural
// FPU responder and a write-back scoreboard.
module tb_fpu_issue_ctrl;

    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst_n;

    fpu_issue_ctrl_if bus();

    fpu_issue_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic [7:0]  delay;
        logic [31:0] value;
        logic [31:0] exp_data;
        logic        illegal;
    } vec_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [4:0]  rd;
        logic [7:0]  delay;
        logic [31:0] value;
    } iss_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    iss_t exp_iss[$];
    wb_t  exp_wb[$];
    vec_t vecs[0:8];

    int   checks = 0;
    int   passes = 0;
    int   start_count = 0;
    bit   model_abort = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // {fpu_start, wb_valid, stall, req_ready, err_timeout, err_illegal}
    function automatic logic [31:0] ctrlBits();
        return 32'({bus.fpu_start, bus.wb_valid, bus.stall, bus.req_ready, bus.err_timeout, bus.err_illegal});
    endfunction

    function automatic logic [31:0] ctrlExp(input bit start, input bit wb, input bit stl,
                                            input bit rdy, input bit tmo, input bit ill);
        return 32'({start, wb, stl, rdy, tmo, ill});
    endfunction

    task automatic checkReset(input string tag);
        checkOutput({tag, "_ctrl"},    ctrlBits(), ctrlExp(0, 0, 0, 1, 0, 0));
        checkOutput({tag, "_fpu_op"},  32'(bus.fpu_op), 32'd0);
        checkOutput({tag, "_fpu_n1"},  bus.fpu_n1, 32'd0);
        checkOutput({tag, "_fpu_n2"},  bus.fpu_n2, 32'd0);
        checkOutput({tag, "_wb_rd"},   32'(bus.wb_rd), 32'd0);
        checkOutput({tag, "_wb_data"}, bus.wb_data, 32'd0);
    endtask

    // FPU responder: checks each start against the expected issue, holds-checks operands, then pulses done.
    iss_t        cur_iss;
    logic [31:0] model_resp;
    initial begin : fpu_model
        bus.fpu_done   = 1'b0;
        bus.fpu_result = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.fpu_start) begin
                start_count++;
                if (exp_iss.size() == 0) begin
                    checkOutput("spurious_start", 32'd1, 32'd0);
                end else begin
                    cur_iss = exp_iss.pop_front();
                    checkOutput("start_op", 32'(bus.fpu_op), 32'(cur_iss.op));
                    checkOutput("start_n1", bus.fpu_n1, cur_iss.n1);
                    checkOutput("start_n2", bus.fpu_n2, cur_iss.n2);
                    checkOutput("start_rd", 32'(bus.wb_rd), 32'(cur_iss.rd));
                    case (cur_iss.op)
                        3'b100:  model_resp = cur_iss.n1 ^ 32'h8000_0000;
                        3'b101:  model_resp = cur_iss.n1;
                        default: model_resp = cur_iss.value;
                    endcase
                    for (int i = 1; i <= int'(cur_iss.delay); i++) begin
                        @(posedge clk);
                        #1;
                        if (model_abort) break;
                        if (i < int'(cur_iss.delay)) begin
                            checkOutput("hold_op", 32'(bus.fpu_op), 32'(cur_iss.op));
                            checkOutput("hold_n1", bus.fpu_n1, cur_iss.n1);
                            checkOutput("hold_n2", bus.fpu_n2, cur_iss.n2);
                            checkOutput("hold_rd", 32'(bus.wb_rd), 32'(cur_iss.rd));
                        end
                    end
                    if (!model_abort) begin
                        bus.fpu_done   = 1'b1;
                        bus.fpu_result = model_resp;
                        @(posedge clk);
                        #1;
                        bus.fpu_done   = 1'b0;
                        bus.fpu_result = '0;
                    end
                end
            end
        end
    end

    // Write-back scoreboard.
    wb_t wb_got;
    always @(negedge clk) begin
        if (rst_n && bus.wb_valid) begin
            if (exp_wb.size() == 0) begin
                checkOutput("unexpected_wb", 32'd1, 32'd0);
            end else begin
                wb_got = exp_wb.pop_front();
                checkOutput("wb_rd", 32'(bus.wb_rd), 32'(wb_got.rd));
                checkOutput("wb_data", bus.wb_data, wb_got.data);
            end
        end
    end

    task automatic pushExpect(input vec_t v, input bit with_wb);
        iss_t iss;
        wb_t  wb;
        iss.op    = v.op;
        iss.n1    = v.rs1;
        iss.n2    = v.rs2;
        iss.rd    = v.rd;
        iss.delay = v.delay;
        iss.value = v.value;
        exp_iss.push_back(iss);
        if (with_wb) begin
            wb.rd   = v.rd;
            wb.data = v.exp_data;
            exp_wb.push_back(wb);
        end
    endtask

    task automatic driveReq(input vec_t v);
        bus.req_valid = 1'b1;
        bus.req_op    = v.op;
        bus.req_rs1   = v.rs1;
        bus.req_rs2   = v.rs2;
        bus.req_rd    = v.rd;
    endtask

    // One request from an IDLE cycle, with per-cycle control timing checks until back in IDLE.
    task automatic applyStimulus(input vec_t v);
        int d;
        d = int'(v.delay);
        @(negedge clk);
        checkOutput("ready_before", 32'(bus.req_ready), 32'd1);
        driveReq(v);
        if (!v.illegal) pushExpect(v, 1'b1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (v.illegal) begin
            @(negedge clk);
            checkOutput("illegal_c1", ctrlBits(), ctrlExp(0, 0, 0, 1, 0, 1));
            @(negedge clk);
            checkOutput("illegal_c2", ctrlBits(), ctrlExp(0, 0, 0, 1, 0, 0));
        end else begin
            for (int c = 1; c <= d + 3; c++) begin
                @(negedge clk);
                checkOutput($sformatf("ctrl_op%0d_c%0d", v.op, c), ctrlBits(),
                            ctrlExp(c == 1, c == d + 2, c <= d + 2, c == d + 3, 0, 0));
            end
        end
    endtask

    initial begin : global_guard
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "[TB] aborted");
    end

    initial begin : main
        vec_t v;
        int   starts0;

        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.req_rd    = '0;
        rst_n         = 1'b0;

        //            op      rs1           rs2           rd     delay  fpu value     expected      illegal
        vecs[0] = '{3'b100, 32'h3F800000, 32'h00000000, 5'd5,  8'd2,  32'h00000000, 32'hBF800000, 1'b0};
        vecs[1] = '{3'b000, 32'h3F800000, 32'h40000000, 5'd1,  8'd10, 32'h40400000, 32'h40400000, 1'b0};
        vecs[2] = '{3'b110, 32'h11111111, 32'h22222222, 5'd3,  8'd0,  32'h00000000, 32'h00000000, 1'b1};
        vecs[3] = '{3'b001, 32'h40400000, 32'h3F800000, 5'd2,  8'd4,  32'h40000000, 32'h40000000, 1'b0};
        vecs[4] = '{3'b010, 32'h40000000, 32'h40400000, 5'd31, 8'd6,  32'h40C00000, 32'h40C00000, 1'b0};
        vecs[5] = '{3'b111, 32'h33333333, 32'h44444444, 5'd9,  8'd0,  32'h00000000, 32'h00000000, 1'b1};
        vecs[6] = '{3'b011, 32'h40C00000, 32'h40000000, 5'd0,  8'd15, 32'h40400000, 32'h40400000, 1'b0};
        vecs[7] = '{3'b101, 32'h12345678, 32'hDEADBEEF, 5'd7,  8'd2,  32'h00000000, 32'h12345678, 1'b0};
        vecs[8] = '{3'b100, 32'hC0490FDB, 32'h00000000, 5'd12, 8'd1,  32'h00000000, 32'h40490FDB, 1'b0};

        #12;
        checkReset("reset_init");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        starts0 = start_count;
        for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);
        checkOutput("start_count_table", 32'(start_count - starts0), 32'd7);

        // Done arriving in the very cycle the watchdog would expire.
        v = '{3'b000, 32'hAAAA0000, 32'h0000BBBB, 5'd20, 8'(TIMEOUT), 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0};
        applyStimulus(v);

`ifdef FPU_ISSUE_TIMEOUT_EN
        // No done within the limit: abort, then a late done three cycles after the error pulse.
        v = '{3'b000, 32'h01010101, 32'h02020202, 5'd21, 8'(TIMEOUT + 4), 32'h77777777, 32'h0, 1'b0};
        @(negedge clk);
        driveReq(v);
        pushExpect(v, 1'b0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        for (int c = 1; c <= TIMEOUT + 7; c++) begin
            @(negedge clk);
            checkOutput($sformatf("wdog_c%0d", c), ctrlBits(),
                        ctrlExp(c == 1, 0, c <= TIMEOUT + 1, c >= TIMEOUT + 2, c == TIMEOUT + 2, 0));
        end
`else
        // Without the watchdog, WAIT simply outlasts the limit and completes normally.
        v = '{3'b010, 32'h01010101, 32'h02020202, 5'd21, 8'(TIMEOUT + 6), 32'h77777777, 32'h77777777, 1'b0};
        applyStimulus(v);
`endif

        // Reset while in WAIT, then a clean mv.
        v = '{3'b000, 32'h0F0F0F0F, 32'hF0F0F0F0, 5'd14, 8'd20, 32'h99999999, 32'h0, 1'b0};
        @(negedge clk);
        driveReq(v);
        pushExpect(v, 1'b0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        model_abort = 1'b1;
        rst_n = 1'b0;
        #1;
        checkReset("reset_wait");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        model_abort = 1'b0;
        v = '{3'b101, 32'h12345678, 32'h00000000, 5'd6, 8'd2, 32'h00000000, 32'h12345678, 1'b0};
        applyStimulus(v);

        // Back-to-back with req_valid held: mul then div.
        starts0 = start_count;
        @(negedge clk);
        v = '{3'b010, 32'h40000000, 32'h40400000, 5'd10, 8'd3, 32'h40C00000, 32'h40C00000, 1'b0};
        driveReq(v);
        pushExpect(v, 1'b1);
        @(posedge clk);
        #1;
        v = '{3'b011, 32'h40C00000, 32'h40000000, 5'd11, 8'd3, 32'h40400000, 32'h40400000, 1'b0};
        driveReq(v);
        pushExpect(v, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            checkOutput($sformatf("b2b_c%0d", c), ctrlBits(),
                        ctrlExp(c == 1 || c == 7, c == 5 || c == 11,
                                !(c == 6 || c == 12), c == 6 || c == 12, 0, 0));
            if (c == 6) begin
                @(posedge clk);
                #1;
                bus.req_valid = 1'b0;
            end
        end
        checkOutput("b2b_start_count", 32'(start_count - starts0), 32'd2);

        repeat (3) @(negedge clk);
        checkOutput("iss_queue_empty", 32'(exp_iss.size()), 32'd0);
        checkOutput("wb_queue_empty", 32'(exp_wb.size()), 32'd0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
